// File: rtl/ring_counter_div.sv
// ring_counter_div: prescaled ring / Johnson counter for LED and scan-select drive.
// A programmable prescaler produces a step every div_val+1 enabled mclk cycles.
// Each step rotates the WIDTH-bit pattern in ring (one-hot) or Johnson mode,
// toward MSB (dir=0) or LSB (dir=1). Registered tick/wrap strobes follow each step.
// Optional feature macro: RC_SELFCORRECT_EN. When defined, illegal patterns are
// replaced by the start pattern at the next step and an err strobe is emitted.
module ring_counter_div #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic [DIV_W-1:0] div_val,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tick,
`ifdef RC_SELFCORRECT_EN
    output logic             err,
`endif
    output logic             wrap
);

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } mode_e;

    logic [DIV_W-1:0] pre_q, pre_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] cnt_d;
    logic             tick_d, wrap_d;
`ifdef RC_SELFCORRECT_EN
    logic             err_d;
`endif

    // Start pattern: the value a full cycle returns to, and the reset/mode-change target.
    function automatic logic [WIDTH-1:0] start_pattern(input mode_e m);
        return (m == MODE_JOHNSON) ? '0 : WIDTH'(1);
    endfunction

    // One rotation step; Johnson mode feeds back the inverted outgoing bit.
    function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] v,
                                                input mode_e m, input logic d);
        logic fb;
        if (d == 1'b0) begin
            fb = (m == MODE_JOHNSON) ? ~v[WIDTH-1] : v[WIDTH-1];
            return {v[WIDTH-2:0], fb};
        end
        fb = (m == MODE_JOHNSON) ? ~v[0] : v[0];
        return {fb, v[WIDTH-1:1]};
    endfunction

`ifdef RC_SELFCORRECT_EN
    // Ring is legal with exactly one bit set; Johnson is legal with at most one
    // boundary between adjacent bits (1..10..0, 0..01..1, all-0, all-1).
    function automatic logic is_illegal(input logic [WIDTH-1:0] v, input mode_e m);
        if (m == MODE_RING)
            return $countones(v) != 1;
        return $countones(v[WIDTH-2:0] ^ v[WIDTH-1:1]) > 1;
    endfunction
`endif

    // Next-state selection: load > mode change > step > hold.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        cnt_d  = cnt;
        pre_d  = pre_q;
        mode_d = mode_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
`ifdef RC_SELFCORRECT_EN
        err_d  = 1'b0;
`endif
        if (load) begin
            cnt_d  = load_val;
            pre_d  = '0;
            mode_d = mode_e'(mode);
        end else if (mode_e'(mode) != mode_q) begin
            cnt_d  = start_pattern(mode_e'(mode));
            pre_d  = '0;
            mode_d = mode_e'(mode);
        end else if (en) begin
            // >= compare: lowering div_val below the running count steps at once.
            if (pre_q >= div_val) begin
                pre_d  = '0;
                tick_d = 1'b1;
`ifdef RC_SELFCORRECT_EN
                if (is_illegal(cnt, mode_q)) begin
                    cnt_d = start_pattern(mode_q);
                    err_d = 1'b1;
                end else begin
                    cnt_d = rotate(cnt, mode_q, dir);
                end
`else
                cnt_d = rotate(cnt, mode_q, dir);
`endif
                wrap_d = (cnt_d == start_pattern(mode_q));
            end else begin
                pre_d = pre_q + DIV_W'(1);
            end
        end
    end

    // State and strobe registers with asynchronous reset.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            cnt    <= WIDTH'(1);
            pre_q  <= '0;
            mode_q <= MODE_RING;
            tick   <= 1'b0;
            wrap   <= 1'b0;
`ifdef RC_SELFCORRECT_EN
            err    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt    <= cnt_d;
            pre_q  <= pre_d;
            mode_q <= mode_d;
            tick   <= tick_d;
            wrap   <= wrap_d;
`ifdef RC_SELFCORRECT_EN
            err    <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ring_counter_div.sv
// tb_ring_counter_div: scoreboard bench for ring_counter_div (WIDTH=8, DIV_W=24).
// The driver computes each expected post-edge output with an arithmetic model
// and queues it; a monitor pops and compares one entry after every rising edge.
// Honours RC_SELFCORRECT_EN when defined.
module tb_ring_counter_div;

    localparam int W  = 8;
    localparam int DW = 24;
    localparam int M  = 1 << W;
    localparam int H  = M / 2;

    logic          mclk = 1'b0;
    logic          rst  = 1'b1;
    logic          en   = 1'b0;
    logic          mode = 1'b0;
    logic          dir  = 1'b0;
    logic          load = 1'b0;
    logic [DW-1:0] div_val  = '0;
    logic [W-1:0]  load_val = '0;
    logic [W-1:0]  cnt;
    logic          tick;
    logic          wrap;
`ifdef RC_SELFCORRECT_EN
    logic          err;
`endif

    ring_counter_div #(.WIDTH(W), .DIV_W(DW)) dut (
        .mclk    (mclk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .dir     (dir),
        .div_val (div_val),
        .load    (load),
        .load_val(load_val),
        .cnt     (cnt),
        .tick    (tick),
`ifdef RC_SELFCORRECT_EN
        .err     (err),
`endif
        .wrap    (wrap)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        int cnt;
        bit tick;
        bit wrap;
        bit err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: pattern as an integer, enabled-cycle count, mode.
    int m_cnt  = 1;
    int m_pre  = 0;
    bit m_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sp(input bit md);
        return md ? 0 : 1;
    endfunction

    // Rotation via multiply/divide: bit shifted out re-enters (inverted for Johnson).
    function automatic int advance(input int x, input bit md, input bit d);
        if (!md) return (d == 1'b0) ? (x * 2) % M + x / H : x / 2 + (x % 2) * H;
        return (d == 1'b0) ? (x * 2) % M + (1 - x / H) : x / 2 + (1 - x % 2) * H;
    endfunction

`ifdef RC_SELFCORRECT_EN
    // Legal ring values are powers of two; legal Johnson values are 2^k-1 or M-2^k.
    function automatic bit legal(input int x, input bit md);
        for (int k = 0; k <= W; k++) begin
            if (!md && k < W && x == (1 << k)) return 1'b1;
            if (md && (x == (1 << k) - 1 || x == M - (1 << k))) return 1'b1;
        end
        return 1'b0;
    endfunction
`endif

    // Apply inputs at the falling edge and queue the expected result of the next rising edge.
    task automatic drive(input bit r, input bit e, input bit md, input bit d,
                         input int dv, input bit ld, input int lv);
        exp_t x;
        bit   bad;
        @(negedge mclk);
        rst = r; en = e; mode = md; dir = d; load = ld;
        div_val  = DW'(dv);
        load_val = W'(lv);
        x.tick = 1'b0; x.wrap = 1'b0; x.err = 1'b0;
        bad = 1'b0;
        if (r) begin
            m_cnt = 1; m_pre = 0; m_mode = 1'b0;
        end else if (ld) begin
            m_cnt = lv; m_pre = 0; m_mode = md;
        end else if (md != m_mode) begin
            m_mode = md; m_cnt = sp(md); m_pre = 0;
        end else if (e) begin
            if (m_pre >= dv) begin
                m_pre  = 0;
                x.tick = 1'b1;
`ifdef RC_SELFCORRECT_EN
                bad = !legal(m_cnt, m_mode);
`endif
                m_cnt  = bad ? sp(m_mode) : advance(m_cnt, m_mode, d);
                x.err  = bad;
                x.wrap = (m_cnt == sp(m_mode));
            end else begin
                m_pre++;
            end
        end
        x.cnt = m_cnt;
        sb.push_back(x);
    endtask

    // Assert reset between edges and verify the outputs clear without a clock edge.
    task automatic async_reset();
        @(posedge mclk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_cnt", 32'(cnt), 32'h01);
        check("async_rst_tick", 32'(tick), 32'h0);
        check("async_rst_wrap", 32'(wrap), 32'h0);
        m_cnt = 1; m_pre = 0; m_mode = 1'b0;
    endtask

    // Monitor: one expected entry per rising edge once the driver has started.
    initial begin
        exp_t x;
        forever begin
            @(posedge mclk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("cnt", 32'(cnt), 32'(x.cnt));
                check("tick", 32'(tick), 32'(x.tick));
                check("wrap", 32'(wrap), 32'(x.wrap));
`ifdef RC_SELFCORRECT_EN
                check("err", 32'(err), 32'(x.err));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    int r_dv  = 3;
    bit r_md  = 1'b0;
    bit r_dir = 1'b0;

    initial begin
        // Reset held, then idle with en=0.
        repeat (3) drive(1, 0, 0, 0, 0, 0, 0);
        repeat (8) drive(0, 0, 0, 0, 0, 0, 0);
        // Ring toward MSB, step every 4 cycles, full revolution plus a bit.
        repeat (36) drive(0, 1, 0, 0, 3, 0, 0);
        // Ring toward LSB, step every cycle.
        repeat (12) drive(0, 1, 0, 1, 0, 0, 0);
        // Switch to Johnson: start pattern, then a full 16-step cycle and more.
        repeat (20) drive(0, 1, 1, 0, 0, 0, 0);
        // Load an illegal ring value (load beats mode change), then one step, then hold.
        drive(0, 1, 0, 0, 0, 1, 8'h05);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        // Divide by 10, async reset mid-count, restart.
        repeat (14) drive(0, 1, 0, 0, 9, 0, 0);
        async_reset();
        drive(1, 1, 0, 0, 9, 0, 0);
        repeat (24) drive(0, 1, 0, 0, 9, 0, 0);
        // Lower div_val below the running prescaler value.
        repeat (6) drive(0, 1, 0, 0, 9, 0, 0);
        repeat (3) drive(0, 1, 0, 0, 1, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) r_dv = $urandom_range(0, 5);
            if ($urandom_range(0, 39) == 0) r_md = ~r_md;
            if ($urandom_range(0, 7) == 0) r_dir = ~r_dir;
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) != 0), r_md, r_dir,
                  r_dv, ($urandom_range(0, 24) == 0), int'($urandom_range(0, 255)));
        end
        drive(0, 0, r_md, r_dir, r_dv, 0, 0);
        repeat (3) @(posedge mclk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ring_counter_div.md
Name: ring_counter_div

Overview:
- Parametrised, prescaled ring/Johnson counter.
- A programmable divider derives a step enable from mclk; each step rotates the WIDTH-bit pattern in ring (one-hot) or Johnson (twisted-ring) mode, in either direction.
- Supports synchronous parallel load and emits step and wrap strobes.
- Drives LED/scan-select patterns from the system clock.

Parameters:
- WIDTH, 8, counter pattern width (>=2)
- DIV_W, 24, prescaler/divide-value width

Ports:
- mclk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- en  input  1  count enable; 0 holds prescaler and cnt
- mode  input  1  0 = ring (one-hot), 1 = Johnson
- dir  input  1  0 = rotate toward MSB, 1 = toward LSB
- div_val  input  DIV_W  step every div_val+1 enabled cycles
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value written on load
- cnt  output  WIDTH  counter pattern (registered)
- tick  output  1  one-cycle pulse, high in first cycle cnt shows a stepped value
- wrap  output  1  one-cycle pulse, high when a step produced the start pattern

Behaviour:
- Reset (async, immediate)
  - cnt = {WIDTH-1 zeros, 1}; prescaler = 0; tick = 0; wrap = 0; internal mode_q = 0.
  - Reset asserted mid-count aborts everything; no pulses while rst = 1.
- Start pattern (SP): ring = 0..01; Johnson = all zeros.
- Priority per edge, highest first: load > mode change > step > hold.
- Load
  - cnt <= load_val; prescaler <= 0; mode_q <= mode; tick = wrap = 0.
  - Independent of en.
- Mode change (mode != mode_q)
  - cnt <= SP of the new mode; prescaler <= 0; mode_q <= mode; no tick, no wrap.
- Prescaler (when en = 1)
  - If prescaler >= div_val: prescaler <= 0 and a step occurs.
  - Otherwise prescaler <= prescaler + 1.
  - div_val = 0 gives a step every cycle.
  - Lowering div_val below the current prescaler value causes a step on the next enabled edge (>= compare); no lockup.
- Step
  - Ring, dir 0: cnt <= {cnt[W-2:0], cnt[W-1]}.
  - Ring, dir 1: cnt <= {cnt[0], cnt[W-1:1]}.
  - Johnson, dir 0: cnt <= {cnt[W-2:0], ~cnt[W-1]}.
  - Johnson, dir 1: cnt <= {~cnt[0], cnt[W-1:1]}.
  - Full cycle: ring = WIDTH steps; Johnson = 2*WIDTH steps.
- tick: registered; 1 for exactly the cycle following a step edge. Steps on consecutive edges give tick held high.
- wrap: registered; 1 alongside tick when the new cnt == SP of mode_q.
- dir may change at any cycle; takes effect on the next step.
- en = 0: prescaler, cnt frozen; tick = wrap = 0.

Optional Feature:
- Macro: RC_SELFCORRECT_EN.
- Defined:
  - Illegal states are replaced at a step with the SP of mode_q instead of the rotated value; wrap is asserted.
    - Ring illegal: popcount(cnt) != 1.
    - Johnson illegal: not of the form 1..10..0 or 0..01..1.
  - Adds output err (1 bit, reset 0), pulsed for one cycle with that step.
  - Loads are accepted raw; correction happens only at the next step.
- Undefined:
  - No err port; illegal patterns rotate unchanged forever.

Test Plan:
1. rst = 1 then 0, en = 0 -> cnt = 8'h01, tick = 0, wrap = 0, held indefinitely.
2. Ring, dir = 0, div_val = 3, en = 1 -> cnt 01,02,04,...,80,01, one step per 4 mclk; tick each step; wrap only on return to 01 (32 cycles).
3. Ring, dir = 1, div_val = 0 -> 01,80,40,20,... every cycle; tick continuously 1.
4. mode 0 -> 1, div_val = 0, dir = 0 -> cnt = 00 next edge, no tick. Then 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00; wrap on 00 after 16 steps.
5. Ring, load = 1, load_val = 8'h05, then one step.
   - With RC_SELFCORRECT_EN: cnt = 05, then 01, err = 1, wrap = 1.
   - Without: 05, then 0A.
6. Counting with div_val = 9; rst pulsed between edges -> cnt = 01 immediately (no edge); prescaler restarts; first post-reset tick 10 enabled cycles later.
